mux_8x1_rr: RTL and testbench

MUX_8X1_RR -- requirements
Module: mux_8x1_rr

---
 rtl/mux_8x1_rr_if.sv | 39 +++
 rtl/mux_8x1_rr.sv | 131 +++++++++++++
 tb/tb_mux_8x1_rr.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_8x1_rr_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux_8x1_rr_if
// Description : Bundle of the eight request/data channels plus the registered
//               output handshake of the round-robin 8:1 capture mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_8x1_rr_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;
    logic [WIDTH-1:0] d5;
    logic [WIDTH-1:0] d6;
    logic [WIDTH-1:0] d7;
    logic [7:0]       gnt;
    logic [WIDTH-1:0] y;
    logic [2:0]       s;
    logic             y_valid;
    logic             y_ready;

    // Sources and sink: drive requests, data and ready; observe grant and output.
    modport master (
        output req, d0, d1, d2, d3, d4, d5, d6, d7, y_ready,
        input  gnt, y, s, y_valid
    );

    // The mux itself.
    modport slave (
        input  req, d0, d1, d2, d3, d4, d5, d6, d7, y_ready,
        output gnt, y, s, y_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_8x1_rr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux_8x1_rr
// Description : Eight-channel round-robin mux feeding a one-entry registered
//               output slot with valid/ready handshake. One item per cycle
//               when the sink keeps up; one-cycle capture latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_8x1_rr #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mux_8x1_rr_if.slave   bus
);

    localparam int c_NUM_CH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t           r_state_q;
    state_t           w_state_d;
    logic [2:0]       r_ptr_q;
    logic [2:0]       w_ptr_d;
    logic [WIDTH-1:0] r_y_q;
    logic [WIDTH-1:0] w_y_d;
    logic [2:0]       r_s_q;
    logic [2:0]       w_s_d;

    logic [WIDTH-1:0] w_d [c_NUM_CH];
    logic             w_slot_free;
    logic             w_found;
    logic             w_grant;
    logic [2:0]       w_idx;
    logic [2:0]       w_cand;
    logic [7:0]       w_gnt;

    assign w_d[0] = bus.d0;
    assign w_d[1] = bus.d1;
    assign w_d[2] = bus.d2;
    assign w_d[3] = bus.d3;
    assign w_d[4] = bus.d4;
    assign w_d[5] = bus.d5;
    assign w_d[6] = bus.d6;
    assign w_d[7] = bus.d7;

    // The slot can take a new item when empty, or when the held item leaves this edge.
    assign w_slot_free = (r_state_q == ST_IDLE) || bus.y_ready;
    // Reset blocks any grant so nothing is acknowledged that will not be captured.
    assign w_grant     = w_slot_free && w_found && !rst;

    // Rotating-priority search: first requesting channel starting at the pointer.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr_q;
        w_cand  = r_ptr_q;
        for (int k = 0; k < c_NUM_CH; k++) begin
            w_cand = r_ptr_q + 3'(k);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // One-hot acknowledge of the channel captured at the coming edge.
    always_comb begin
        w_gnt = 8'h00;
        if (w_grant) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    // Next state: capture on grant, drain to IDLE when the sink takes the last item.
    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_y_d     = r_y_q;
        w_s_d     = r_s_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_d = ST_FULL;
                    w_y_d     = w_d[w_idx];
                    w_s_d     = w_idx;
                    w_ptr_d   = w_idx + 3'd1;
                end
            end
            ST_FULL: begin
                if (w_grant) begin
                    w_state_d = ST_FULL;
                    w_y_d     = w_d[w_idx];
                    w_s_d     = w_idx;
                    w_ptr_d   = w_idx + 3'd1;
                end else if (bus.y_ready) begin
                    // Item leaves with nothing behind it; y and s keep their values.
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers; reset discards any held item.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_ptr_q   <= 3'd0;
            r_y_q     <= '0;
            r_s_q     <= 3'd0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_y_q     <= w_y_d;
            r_s_q     <= w_s_d;
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.y       = r_y_q;
    assign bus.s       = r_s_q;
    assign bus.y_valid = (r_state_q == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_mux_8x1_rr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mux_8x1_rr
// Description : Self-checking bench for mux_8x1_rr: vector table plus
//               directed sequences, with a scoreboard of captured items.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_8x1_rr;

    logic       clk;
    logic       rst;
    logic [7:0] tb_d [8];

    mux_8x1_rr_if #(.WIDTH(8)) bus ();

    mux_8x1_rr #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.d0 = tb_d[0];
    assign bus.d1 = tb_d[1];
    assign bus.d2 = tb_d[2];
    assign bus.d3 = tb_d[3];
    assign bus.d4 = tb_d[4];
    assign bus.d5 = tb_d[5];
    assign bus.d6 = tb_d[6];
    assign bus.d7 = tb_d[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] s;
    } item_t;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] gnt;
    } vec_t;

    item_t sb [$];
    logic [2:0] m_ptr;
    bit         m_full;
    int         n_chk;
    int         n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: rotating search from the model pointer.
    function automatic logic [7:0] model_gnt(input logic r, input logic [7:0] rq, input logic rdy);
        logic [7:0] g;
        logic [2:0] idx;
        bit         hit;
        g   = 8'h00;
        hit = 1'b0;
        if (!r && (!m_full || rdy)) begin
            for (int k = 0; k < 8; k++) begin
                idx = m_ptr + 3'(k);
                if (!hit && rq[idx]) begin
                    hit    = 1'b1;
                    g[idx] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock cycle: drive, check pre-edge outputs, advance model and scoreboard.
    task automatic cycle(input logic r, input logic [7:0] rq, input logic rdy, output logic [7:0] obs_gnt);
        logic [7:0] eg;
        int         widx;
        rst            = r;
        bus.req        = rq;
        bus.y_ready    = rdy;
        #1;
        obs_gnt = bus.gnt;
        eg      = model_gnt(r, rq, rdy);
        chk("gnt_model", bus.gnt, eg);
        chk("y_valid_model", bus.y_valid, m_full);
        if (m_full) begin
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                chk("sb_y", bus.y, sb[0].y);
                chk("sb_s", bus.s, sb[0].s);
            end
        end
        @(posedge clk);
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 3'd0;
            sb.delete();
        end else begin
            if (m_full && rdy && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            if (eg != 8'h00) begin
                widx = 0;
                for (int k = 0; k < 8; k++) begin
                    if (eg[k]) widx = k;
                end
                sb.push_back({tb_d[widx], 3'(widx)});
                m_ptr  = 3'(widx) + 3'd1;
                m_full = 1'b1;
            end else if (m_full && rdy) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic post(input string tag, input logic [7:0] ey, input logic [2:0] es, input logic ev);
        chk({tag, "_y"}, bus.y, ey);
        chk({tag, "_s"}, bus.s, es);
        chk({tag, "_valid"}, bus.y_valid, ev);
    endtask

    vec_t       tbl [16];
    logic [7:0] g;
    logic [7:0] ey;

    initial begin
        n_chk       = 0;
        n_err       = 0;
        m_ptr       = 3'd0;
        m_full      = 1'b0;
        rst         = 1'b1;
        bus.req     = 8'h00;
        bus.y_ready = 1'b0;
        for (int i = 0; i < 8; i++) tb_d[i] = 8'h10 + 8'(i);

        tbl[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 8'h01, 1'b1, 8'h01};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 8'h21, 1'b0, 8'h20};
        tbl[4]  = '{1'b0, 8'h21, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h21, 1'b1, 8'h01};
        tbl[6]  = '{1'b0, 8'h80, 1'b1, 8'h80};
        tbl[7]  = '{1'b0, 8'hC0, 1'b1, 8'h40};
        tbl[8]  = '{1'b0, 8'hC0, 1'b1, 8'h80};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 8'hFF, 1'b1, 8'h01};
        tbl[13] = '{1'b1, 8'hFF, 1'b1, 8'h00};
        tbl[14] = '{1'b0, 8'hFF, 1'b0, 8'h01};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 8'h00};

        // Power-up reset, then check the reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        post("reset", 8'h00, 3'd0, 1'b0);
        chk("reset_gnt", bus.gnt, 8'h00);
        @(negedge clk);

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].rdy, g);
            chk($sformatf("tbl%0d_gnt", i), g, tbl[i].gnt);
        end
        post("tbl_rst_release", 8'h10, 3'd0, 1'b0);

        // Full-rate round robin with every channel requesting.
        cycle(1'b1, 8'h00, 1'b0, g);
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 8'hFF, 1'b1, g);
            ey = 8'h10 + 8'(k % 8);
            post($sformatf("rr%0d", k), ey, 3'(k % 8), 1'b1);
        end

        // First capture after reset, then pointer advanced to 1.
        tb_d[0] = 8'hA5;
        cycle(1'b1, 8'h00, 1'b0, g);
        cycle(1'b0, 8'h01, 1'b1, g);
        chk("first_gnt", g, 8'h01);
        post("first", 8'hA5, 3'd0, 1'b1);
        cycle(1'b0, 8'h03, 1'b1, g);
        chk("ptr1_gnt", g, 8'h02);
        cycle(1'b0, 8'h00, 1'b1, g);

        // Backpressure hold, then release with same-cycle grant.
        tb_d[3] = 8'h33;
        tb_d[7] = 8'h77;
        cycle(1'b1, 8'h00, 1'b0, g);
        cycle(1'b0, 8'h08, 1'b1, g);
        post("bp_load", 8'h33, 3'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h80, 1'b0, g);
            chk($sformatf("bp%0d_gnt", k), g, 8'h00);
            post($sformatf("bp%0d", k), 8'h33, 3'd3, 1'b1);
        end
        cycle(1'b0, 8'h80, 1'b1, g);
        chk("bp_release_gnt", g, 8'h80);
        post("bp_release", 8'h77, 3'd7, 1'b1);

        // Drain to IDLE: valid drops, data and index retained.
        cycle(1'b0, 8'h00, 1'b1, g);
        post("drain", 8'h77, 3'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
